insn_queue: RTL and testbench
=============================

// Module: insn_queue
// PURPOSE
// - Decoupling queue between instruction fetch and decode in the single-cycle-derived RISC-V core.
// - Captures {pc, insn} pairs from fetch.
// - Throttles fetch by driving the pc_gen enable.
// - Presents the oldest entry to decode with a valid/ready handshake.
// - Discards all contents on a control-flow redirect (flush).
// PARAMETERS
// - DEPTH  4   number of entries; power of 2, >= 2
// - XLEN   32  pc and instruction width
// PORTS
// - i_clk       in   1                  core clock; all state updates on rising edge
// - i_rst       in   1                  asynchronous, active-high reset
// - i_fetch_vld in   1                  fetch presents a valid pc/insn this cycle
// - i_fetch_pc  in   XLEN               pc of the fetched instruction
// - i_fetch_insn in  XLEN               fetched instruction word
// - o_fetch_rdy out  1                  queue can accept; wired to pc_gen i_pc_en
// - i_flush     in   1                  redirect (branch/jump taken); kills all entries
// - o_dec_vld   out  1                  head entry valid
// - o_dec_pc    out  XLEN               head pc
// - o_dec_insn  out  XLEN               head instruction
// - o_dec_cls   out  4                  head predecode class (cls_e)
// - i_dec_rdy   in   1                  decode consumes head this cycle
// - o_count     out  $clog2(DEPTH)+1    current occupancy
// BEHAVIOUR
// - Reset values:
//   - wr_ptr = rd_ptr = 0.
//   - o_count = 0, o_dec_vld = 0, o_fetch_rdy = 1.
//   - o_dec_pc, o_dec_insn, o_dec_cls = 0.
//   - Storage contents: don't-care.
// - Pointers: $clog2(DEPTH)+1 bits each; the MSB distinguishes full from empty; natural wrap.
// - Full/empty: empty = (wr_ptr == rd_ptr); full = addr bits equal and MSBs differ.
// - o_fetch_rdy = !full.
//   - Registered-state function only; no combinational path from i_dec_rdy.
//   - A full queue therefore does not accept on the same cycle it pops.
// - push = i_fetch_vld & o_fetch_rdy & !i_flush.
//   - Writes entry at wr_ptr; wr_ptr++.
// - pop = o_dec_vld & i_dec_rdy & !i_flush.
//   - rd_ptr++.
// - o_dec_vld = !empty.
//   - o_dec_* is a combinational read of entry[rd_ptr]; data is stable while vld && !rdy.
// - Latency: an entry pushed in cycle N is visible at o_dec_* in cycle N+1 (one cycle, including when empty).
// - Simultaneous push and pop (not full, not empty): both happen; o_count unchanged.
// - Flush has priority over push and pop.
//   - Next cycle: rd_ptr <= wr_ptr, o_count = 0, o_dec_vld = 0.
//   - Same-cycle push and pop are suppressed.
// - Reset mid-operation clears the pointers immediately (async); in-flight entries are lost.
// - Widths: o_count = wr_ptr - rd_ptr, modulo 2^(ptr width). No other arithmetic.
// CONFIGURATION
// - Macro: INSN_QUEUE_PREDECODE_EN.
// - Defined:
//   - On push, the insn_predecode class of insn[6:0] is stored with the entry.
//   - o_dec_cls shows the head's class.
//   - Mapping:
//     - 0110011/0010011 -> CLS_ALU
//     - 0000011 -> CLS_LOAD
//     - 0100011 -> CLS_STORE
//     - 1100011 -> CLS_BRANCH
//     - 1101111/1100111 -> CLS_JUMP
//     - 0110111/0010111 -> CLS_UPPER
//     - 1110011 -> CLS_SYSTEM
//     - else -> CLS_ILLEGAL
// - Undefined:
//   - No class storage; o_dec_cls is tied to CLS_NONE (4'h0).
//   - All other behaviour is identical.
// STRUCTURE
// - Package insn_queue_pkg:
//   - cls_e (4-bit enum: CLS_NONE=0, ALU, LOAD, STORE, BRANCH, JUMP, UPPER, SYSTEM, ILLEGAL).
//   - RV32I opcode localparams.
//   - Entry struct q_entry_t {pc, insn, cls}.
// - Sub-module insn_predecode:
//   - Combinational insn[6:0] -> cls_e.
//   - Instantiated only under INSN_QUEUE_PREDECODE_EN.
// - Storage: flop array q_entry_t [DEPTH].
// TESTING
// - Reset: assert i_rst mid-stream with 3 entries held.
//   - Same cycle: o_dec_vld = 0, o_count = 0, o_fetch_rdy = 1.
// - Fill: i_dec_rdy = 0; push pc 0x0, 0x4, 0x8, 0xC.
//   - o_count = 4, o_fetch_rdy = 0.
//   - A 5th push (pc 0x10) is ignored; head stays pc 0x0.
// - Stream: i_fetch_vld = 1 and i_dec_rdy = 1 continuously from empty.
//   - o_dec_pc sequence lags the input by 1 cycle; o_count holds at 1.
// - Full + pop: queue full, i_dec_rdy = 1, i_fetch_vld = 1.
//   - Pop occurs, push does not; o_count = 3.
//   - Next cycle the push is accepted.
// - Flush: 3 entries held; i_flush = 1 with i_fetch_vld = 1 and i_dec_rdy = 1.
//   - Next cycle: o_count = 0, o_dec_vld = 0.
//   - Push of pc 0x40 the following cycle appears at the head.
// - Wrap and predecode: 3*DEPTH push/pop cycles with random stall.
//   - Order is preserved across pointer wrap.
//   - With INSN_QUEUE_PREDECODE_EN: insn 0x00000063 -> CLS_BRANCH, insn 0x00000000 -> CLS_ILLEGAL.
//   - Without the macro: o_dec_cls = 0.

Source files
------------

// File: rtl/insn_queue_pkg.sv
// -----------------------------------------------------------------------------
// insn_queue_pkg
//   Shared types and constants for the fetch -> decode instruction queue.
//   - cls_e     : 4-bit predecode class carried with each queued instruction
//   - OP_*      : RV32I major opcodes (insn[6:0]) used by the predecoder
//   - q_entry_t : one queue slot {pc, insn, cls}
//   - Q_XLEN    : pc / instruction width of a queue slot; the queue's XLEN
//                 parameter must match it.
// -----------------------------------------------------------------------------
package insn_queue_pkg;

    localparam int Q_XLEN = 32;

    typedef enum logic [3:0] {
        CLS_NONE    = 4'd0,
        CLS_ALU     = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JUMP    = 4'd5,
        CLS_UPPER   = 4'd6,
        CLS_SYSTEM  = 4'd7,
        CLS_ILLEGAL = 4'd8
    } cls_e;

    // RV32I major opcodes
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [Q_XLEN-1:0] pc;
        logic [Q_XLEN-1:0] insn;
        cls_e              cls;
    } q_entry_t;

endpackage

// File: rtl/insn_predecode.sv
// -----------------------------------------------------------------------------
// insn_predecode
//   Purely combinational classification of an RV32I instruction by its major
//   opcode, so decode gets a coarse class one stage early.
//   Ports:
//     opcode in  7     insn[6:0] of the instruction being queued
//     cls    out cls_e class of that opcode (CLS_ILLEGAL if not RV32I)
// -----------------------------------------------------------------------------
module insn_predecode
    import insn_queue_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_e       cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_OP, OP_OP_IMM: cls = CLS_ALU;
            OP_LOAD:          cls = CLS_LOAD;
            OP_STORE:         cls = CLS_STORE;
            OP_BRANCH:        cls = CLS_BRANCH;
            OP_JAL, OP_JALR:  cls = CLS_JUMP;
            OP_LUI, OP_AUIPC: cls = CLS_UPPER;
            OP_SYSTEM:        cls = CLS_SYSTEM;
            default:          cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/insn_queue.sv
// -----------------------------------------------------------------------------
// insn_queue
//   Decoupling FIFO between instruction fetch and decode. Captures {pc, insn}
//   from fetch, throttles pc_gen via o_fetch_rdy, presents the oldest entry to
//   decode with a valid/ready handshake, and drops everything on a redirect.
//
//   Optional feature: define INSN_QUEUE_PREDECODE_EN to store a predecode
//   class with each entry (shown on o_dec_cls). Without it o_dec_cls is 0.
//
//   Parameters:
//     DEPTH  number of entries (power of 2, >= 2)
//     XLEN   pc / instruction width (must equal insn_queue_pkg::Q_XLEN)
//   Ports:
//     i_clk, i_rst            clock, asynchronous active-high reset
//     i_fetch_vld/pc/insn     fetch side write
//     o_fetch_rdy             queue can accept (drives pc_gen enable)
//     i_flush                 redirect: kills all entries, blocks push/pop
//     o_dec_vld/pc/insn/cls   head entry to decode (zero when empty)
//     i_dec_rdy               decode consumes head
//     o_count                 occupancy
// -----------------------------------------------------------------------------
module insn_queue
    import insn_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_fetch_vld,
    input  logic [XLEN-1:0]            i_fetch_pc,
    input  logic [XLEN-1:0]            i_fetch_insn,
    output logic                       o_fetch_rdy,
    input  logic                       i_flush,
    output logic                       o_dec_vld,
    output logic [XLEN-1:0]            o_dec_pc,
    output logic [XLEN-1:0]            o_dec_insn,
    output logic [3:0]                 o_dec_cls,
    input  logic                       i_dec_rdy,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;

    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    q_entry_t         entry_reg [DEPTH];
    q_entry_t         wr_entry;
    q_entry_t         head;
    logic [DEPTH-1:0] wr_sel;

    assign wr_addr = wr_ptr_reg[AW-1:0];
    assign rd_addr = rd_ptr_reg[AW-1:0];

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_addr == rd_addr) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    // Ready depends only on registered pointers, so a full queue cannot
    // accept in the same cycle it pops; this keeps i_dec_rdy off the
    // pc_gen enable path.
    assign o_fetch_rdy = !full;
    assign o_dec_vld   = !empty;

    assign push = i_fetch_vld && o_fetch_rdy && !i_flush;
    assign pop  = o_dec_vld && i_dec_rdy && !i_flush;

    // ------------------------------------------------------------------
    // Entry to be written on push
    // ------------------------------------------------------------------
`ifdef INSN_QUEUE_PREDECODE_EN
    cls_e fetch_cls;

    insn_predecode u_predecode (
        .opcode (i_fetch_insn[6:0]),
        .cls    (fetch_cls)
    );
`endif

    always_comb begin
        wr_entry      = '0;
        wr_entry.pc   = i_fetch_pc;
        wr_entry.insn = i_fetch_insn;
`ifdef INSN_QUEUE_PREDECODE_EN
        wr_entry.cls  = fetch_cls;
`else
        // Constant class; storage for it folds away in synthesis.
        wr_entry.cls  = CLS_NONE;
`endif
    end

    // ------------------------------------------------------------------
    // Pointer next-state. Flush wins: read pointer jumps to the write
    // pointer, which drops every held entry in one cycle.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (i_flush) begin
            rd_ptr_next = wr_ptr_reg;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Storage: per-slot write enables, contents not reset (don't-care
    // until written; outputs are masked while empty).
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push && (wr_addr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                entry_reg[i] <= wr_entry;
            end
        end
    end

    // ------------------------------------------------------------------
    // Head read: combinational, so an entry written at edge N is visible
    // right after that edge. Zeroed while empty so reset/flush present
    // clean outputs without resetting the storage.
    // ------------------------------------------------------------------
    assign head = entry_reg[rd_addr];

    always_comb begin
        o_dec_pc   = '0;
        o_dec_insn = '0;
        o_dec_cls  = CLS_NONE;
        if (!empty) begin
            o_dec_pc   = head.pc;
            o_dec_insn = head.insn;
            o_dec_cls  = head.cls;
        end
    end

    // Occupancy: modulo difference of the extended pointers.
    assign o_count = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: tb/tb_insn_queue.sv
// -----------------------------------------------------------------------------
// tb_insn_queue
//   Self-checking bench for insn_queue. A queue of {pc, insn} records acts as
//   the reference; each cycle the DUT outputs are compared against the model
//   before the clock edge, then the model applies the same push/pop/flush.
// -----------------------------------------------------------------------------
module tb_insn_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_fetch_vld;
    logic [XLEN-1:0]   i_fetch_pc;
    logic [XLEN-1:0]   i_fetch_insn;
    logic              o_fetch_rdy;
    logic              i_flush;
    logic              o_dec_vld;
    logic [XLEN-1:0]   o_dec_pc;
    logic [XLEN-1:0]   o_dec_insn;
    logic [3:0]        o_dec_cls;
    logic              i_dec_rdy;
    logic [$clog2(DEPTH):0] o_count;

    insn_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fetch_vld  (i_fetch_vld),
        .i_fetch_pc   (i_fetch_pc),
        .i_fetch_insn (i_fetch_insn),
        .o_fetch_rdy  (o_fetch_rdy),
        .i_flush      (i_flush),
        .o_dec_vld    (o_dec_vld),
        .o_dec_pc     (o_dec_pc),
        .o_dec_insn   (o_dec_insn),
        .o_dec_cls    (o_dec_cls),
        .i_dec_rdy    (i_dec_rdy),
        .o_count      (o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;

    ent_t model_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Expected predecode class from the RV32I opcode table.
    function automatic logic [3:0] exp_cls(input logic [31:0] insn);
`ifdef INSN_QUEUE_PREDECODE_EN
        case (insn[6:0])
            7'h33, 7'h13: return 4'd1;
            7'h03:        return 4'd2;
            7'h23:        return 4'd3;
            7'h63:        return 4'd4;
            7'h6f, 7'h67: return 4'd5;
            7'h37, 7'h17: return 4'd6;
            7'h73:        return 4'd7;
            default:      return 4'd8;
        endcase
`else
        return 4'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = model_q.size();
        check("count",     64'(o_count),     64'(sz));
        check("fetch_rdy", 64'(o_fetch_rdy), 64'(sz < DEPTH));
        check("dec_vld",   64'(o_dec_vld),   64'(sz > 0));
        if (sz > 0) begin
            check("dec_pc",   64'(o_dec_pc),   64'(model_q[0].pc));
            check("dec_insn", 64'(o_dec_insn), 64'(model_q[0].insn));
            check("dec_cls",  64'(o_dec_cls),  64'(exp_cls(model_q[0].insn)));
        end else begin
            check("dec_pc_empty",  64'(o_dec_pc),  64'h0);
            check("dec_cls_empty", 64'(o_dec_cls), 64'h0);
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs, advance the model.
    task automatic step(input logic vld, input logic [31:0] pc, input logic [31:0] insn,
                        input logic flush, input logic rdy);
        logic do_push, do_pop;
        ent_t e;
        i_fetch_vld  = vld;
        i_fetch_pc   = pc;
        i_fetch_insn = insn;
        i_flush      = flush;
        i_dec_rdy    = rdy;
        @(negedge i_clk);
        check_outputs();
        do_push = vld && (model_q.size() < DEPTH) && !flush;
        do_pop  = (model_q.size() > 0) && rdy && !flush;
        @(posedge i_clk);
        if (flush) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.pc   = pc;
                e.insn = insn;
                model_q.push_back(e);
            end
        end
        $display("[TB] cyc %0d vld=%b pc=%h flush=%b rdy=%b push=%b pop=%b occ=%0d",
                 cyc, vld, pc, flush, rdy, do_push, do_pop, model_q.size());
        cyc++;
        #1;
    endtask

    logic [6:0] op_tbl [12];

    initial begin
        logic [31:0] r;
        op_tbl = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f,
                   7'h67, 7'h37, 7'h17, 7'h73, 7'h00, 7'h7f};

        i_rst = 1'b1; i_fetch_vld = 1'b0; i_fetch_pc = '0; i_fetch_insn = '0;
        i_flush = 1'b0; i_dec_rdy = 1'b0;

        // Reset state
        #3;
        check("rst_vld",   64'(o_dec_vld),   64'h0);
        check("rst_count", 64'(o_count),     64'h0);
        check("rst_rdy",   64'(o_fetch_rdy), 64'h1);
        check("rst_pc",    64'(o_dec_pc),    64'h0);
        check("rst_insn",  64'(o_dec_insn),  64'h0);
        check("rst_cls",   64'(o_dec_cls),   64'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Fill with decode stalled, then try a fifth push
        for (int k = 0; k < 4; k++) step(1'b1, 32'(4 * k), 32'h0000_0013 + 32'(k << 20), 1'b0, 1'b0);
        step(1'b1, 32'h10, 32'h0000_0033, 1'b0, 1'b0);
        check("fill_count", 64'(o_count),     64'h4);
        check("fill_rdy",   64'(o_fetch_rdy), 64'h0);
        check("fill_head",  64'(o_dec_pc),    64'h0);

        // Full + pop: pop happens, push refused, then accepted next cycle
        step(1'b1, 32'h14, 32'h0000_0013, 1'b0, 1'b1);
        check("fullpop_count", 64'(o_count),  64'h3);
        check("fullpop_head",  64'(o_dec_pc), 64'h4);
        step(1'b1, 32'h18, 32'h0000_0013, 1'b0, 1'b0);
        check("fullpop_accept", 64'(o_count), 64'h4);

        // Drain
        for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Streaming from empty: occupancy holds at 1, head lags by one
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 32'h100 + 32'(4 * k), 32'h0000_0003, 1'b0, 1'b1);
            check("stream_count", 64'(o_count),  64'h1);
            check("stream_head",  64'(o_dec_pc), 64'h100 + 64'(4 * k));
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Flush with 3 entries and competing push/pop
        for (int k = 0; k < 3; k++) step(1'b1, 32'h200 + 32'(4 * k), 32'h0000_0023, 1'b0, 1'b0);
        step(1'b1, 32'h30, 32'h0000_0013, 1'b1, 1'b1);
        check("flush_count", 64'(o_count),   64'h0);
        check("flush_vld",   64'(o_dec_vld), 64'h0);
        step(1'b1, 32'h40, 32'h0000_006f, 1'b0, 1'b0);
        check("flush_next_head", 64'(o_dec_pc),  64'h40);
        check("flush_next_vld",  64'(o_dec_vld), 64'h1);

        // Asynchronous reset with 3 entries held
        step(1'b1, 32'h44, 32'h0000_0013, 1'b0, 1'b0);
        step(1'b1, 32'h48, 32'h0000_0013, 1'b0, 1'b0);
        check("prerst_count", 64'(o_count), 64'h3);
        i_fetch_vld = 1'b0; i_dec_rdy = 1'b0;
        #1 i_rst = 1'b1;
        #1;
        check("midrst_vld",   64'(o_dec_vld),   64'h0);
        check("midrst_count", 64'(o_count),     64'h0);
        check("midrst_rdy",   64'(o_fetch_rdy), 64'h1);
        model_q.delete();
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Predecode classes
        step(1'b1, 32'h300, 32'h0000_0063, 1'b0, 1'b0);
        step(1'b1, 32'h304, 32'h0000_0000, 1'b0, 1'b0);
`ifdef INSN_QUEUE_PREDECODE_EN
        check("pd_branch", 64'(o_dec_cls), 64'h4);
`else
        check("pd_branch", 64'(o_dec_cls), 64'h0);
`endif
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
`ifdef INSN_QUEUE_PREDECODE_EN
        check("pd_illegal", 64'(o_dec_cls), 64'h8);
`else
        check("pd_illegal", 64'(o_dec_cls), 64'h0);
`endif
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Randomised push/pop with stalls and rare flush; spans many wraps
        for (int k = 0; k < 15 * DEPTH; k++) begin
            logic v, rd, fl;
            r  = $urandom;
            v  = ($urandom_range(0, 9) < 7);
            rd = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 29) == 0);
            step(v, 32'h1000 + 32'(4 * k), {r[31:7], op_tbl[$urandom_range(0, 11)]}, fl, rd);
        end
        for (int k = 0; k < DEPTH + 1; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
